exec_mult_seq: RTL
==================

# exec_mult_seq

Iterative shift-add multiplier sequencer attached alongside the execute stage. It adds a MUL class of operation without lengthening the single-cycle ALU path. It accepts a one-cycle start request with two 16-bit operands and holds the pipeline through a stall output while it iterates one multiplier bit per cycle. It then presents a registered 32-bit product with a one-cycle done pulse that the execute stage muxes onto its ALU result.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH; iteration count equals WIDTH
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- sign  in  1  1 = signed (two's complement) operands, 0 = unsigned
- A  in  WIDTH  multiplicand, sampled with start
- B  in  WIDTH  multiplier, sampled with start
- flush  in  1  abort in-flight operation (branch/jump squash)
- stall  out  1  freeze upstream pipeline registers
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, product valid
- prodLo  out  WIDTH  product bits [WIDTH-1:0]
- prodHi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
- ofl  out  1  product does not fit in WIDTH bits
- err  out  1  one-cycle pulse, start received while busy

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start & ~flush:
  - latch mcand=A, accumulator {hi,lo}={0,B}, count=0, neg flag
  - go RUN
- RUN, each cycle:
  - if lo[0], hi_ext = {1'b0,hi} + {1'b0,mcand} (WIDTH+1 bits, carry kept)
  - {hi,lo} = {hi_ext,lo} >> 1
  - count++
  - after WIDTH iterations go DONE
- DONE:
  - prodHi/prodLo/ofl registered from the accumulator (negated if neg flag set)
  - done=1 for this cycle only
  - next state IDLE
- Results hold until the next DONE or rst.
- ofl:
  - unsigned: prodHi != 0
  - signed: prodHi is not the sign extension of prodLo[WIDTH-1]
- flush in RUN: return to IDLE next cycle, no done, result registers unchanged.
- flush in IDLE with start: flush wins, no operation begins.
- flush in DONE: ignored (result already committed).
- start in RUN or DONE: ignored, err=1 that cycle, operation continues unaffected.
- stall = (IDLE & start & ~flush) | RUN, combinational, so the MUL instruction is held in execute from its first cycle.

## Timing
- Reset values: state IDLE, count 0, prodLo=prodHi=0, ofl=0, done=0, err=0, busy=0, stall=0 (stall ignores inputs during rst).
- start sampled at edge E0 → RUN during cycles 1..WIDTH → DONE (done=1) in cycle WIDTH+1 → IDLE in cycle WIDTH+2.
- Latency start-to-done: WIDTH+1 = 17 cycles.
- Back-to-back: a new start is accepted in the cycle after DONE, so throughput is one product per WIDTH+2 cycles.
- busy is high in cycles 1..WIDTH+1.
- stall is high in cycles 0..WIDTH and low in the DONE cycle, so the pipeline advances while capturing the product.
- rst mid-RUN: IDLE next edge; outputs return to reset values.

## Configuration
- MULT_SIGNED_EN defined:
  - when sign=1, operands are converted to magnitudes at start
  - neg = A[WIDTH-1]^B[WIDTH-1]
  - the final 2*WIDTH result is two's-complement negated in the DONE transition when neg=1
  - ofl uses the signed rule
- MULT_SIGNED_EN undefined:
  - sign input is ignored
  - all operations are unsigned, neg is constant 0
  - ofl uses the unsigned rule
  - no negation logic is synthesized

## Test plan
- Reset, then unsigned 0x0003*0x0005 → done exactly 17 cycles after start; prodHi=0x0000, prodLo=0x000F, ofl=0; stall high for 17 cycles (cycles 0..16), low in the done cycle.
- Unsigned 0xFFFF*0xFFFF → prodHi=0xFFFE, prodLo=0x0001, ofl=1. Then immediate next start 0x0000*0x1234 → result 0, ofl=0, done 17 cycles later.
- With MULT_SIGNED_EN:
  - signed 0xFFFD*0x0005 → 0xFFFF_FFF1, ofl=0
  - signed 0x8000*0x8000 → 0x4000_0000, ofl=1
  - signed 0xFFFF*0xFFFF → 0x0000_0001
  - without the macro, the same 0xFFFF*0xFFFF with sign=1 → 0xFFFE_0001
- flush asserted in cycle 8 of RUN → busy drops next cycle, no done pulse, prodHi/prodLo keep the prior result. Start with flush in the same IDLE cycle → no stall, no busy.
- start pulsed during RUN → err=1 for that single cycle; the original product completes with correct value and timing.
- rst asserted mid-RUN → next cycle all outputs at reset values. A fresh start then completes normally.

Source files
------------

// File: rtl/exec_mult_seq_if.sv
// rtl/exec_mult_seq_if.sv - request/result bundle between execute stage and multiplier sequencer
//
// Purpose: carries the multiply request (start/sign/operands/flush) from the
// execute stage and the stall/status/product back to it.
// Ports (by modport):
//   master (execute stage): drives start, sign, A, B, flush;
//                           receives stall, busy, done, prodLo, prodHi, ofl, err
//   slave  (multiplier)   : the mirror image of master
interface exec_mult_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prodLo;
    logic [WIDTH-1:0] prodHi;
    logic             ofl;
    logic             err;

    modport master (
        output start, sign, A, B, flush,
        input  stall, busy, done, prodLo, prodHi, ofl, err
    );

    modport slave (
        input  start, sign, A, B, flush,
        output stall, busy, done, prodLo, prodHi, ofl, err
    );
endinterface

// File: rtl/exec_mult_seq.sv
// rtl/exec_mult_seq.sv - iterative shift-add multiplier sequencer beside the execute stage
//
// Purpose: accepts a one-cycle start with two WIDTH-bit operands, stalls the
// pipeline while it retires one multiplier bit per cycle (WIDTH cycles), then
// presents a registered 2*WIDTH-bit product with a one-cycle done pulse.
// Optional feature macro: MULT_SIGNED_EN (signed operands via sign input).
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - exec_mult_seq_if.slave: start, sign, A, B, flush in;
//          stall, busy, done, prodLo, prodHi, ofl, err out
module exec_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    exec_mult_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] prod_hi;
    logic             ofl_r;
    logic             done_r;

    logic [WIDTH:0]       hi_ext;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   result;
    logic                 ofl_next;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;

    // One shift-add step; the carry out of the add becomes the new top bit
    // after the shift, so no product bit is lost.
    always_comb begin
        hi_ext = {1'b0, hi};
        if (lo[0]) begin
            hi_ext = {1'b0, hi} + {1'b0, mcand};
        end
        acc_next = {hi_ext, lo[WIDTH-1:1]};
    end

`ifdef MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic neg;
    logic op_signed;

    // Signed requests iterate on magnitudes; the sign is restored at the end.
    always_comb begin
        op_a = bus.A;
        op_b = bus.B;
        if (bus.sign && bus.A[WIDTH-1]) begin
            op_a = ~bus.A + ONE_W;
        end
        if (bus.sign && bus.B[WIDTH-1]) begin
            op_b = ~bus.B + ONE_W;
        end
    end

    // Product is taken from the last step's accumulator so that it is
    // already registered in the DONE cycle alongside the done pulse.
    always_comb begin
        result = acc_next;
        if (neg) begin
            result = ~acc_next + ONE_P;
        end
        if (op_signed) begin
            ofl_next = (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}});
        end else begin
            ofl_next = |result[2*WIDTH-1:WIDTH];
        end
    end
`else
    logic unused_sign;
    assign unused_sign = bus.sign;

    always_comb begin
        op_a     = bus.A;
        op_b     = bus.B;
        result   = acc_next;
        ofl_next = |acc_next[2*WIDTH-1:WIDTH];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            prod_lo <= '0;
            prod_hi <= '0;
            ofl_r   <= 1'b0;
            done_r  <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg       <= 1'b0;
            op_signed <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // flush squashes a same-cycle start
                    if (bus.start && !bus.flush) begin
                        mcand <= op_a;
                        hi    <= '0;
                        lo    <= op_b;
                        count <= '0;
`ifdef MULT_SIGNED_EN
                        neg       <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        op_signed <= bus.sign;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        // abandon the operation; committed result untouched
                        state <= IDLE;
                    end else begin
                        {hi, lo} <= acc_next;
                        count    <= count + CW'(1);
                        if (count == LAST) begin
                            state   <= DONE;
                            done_r  <= 1'b1;
                            prod_hi <= result[2*WIDTH-1:WIDTH];
                            prod_lo <= result[WIDTH-1:0];
                            ofl_r   <= ofl_next;
                        end
                    end
                end
                DONE: begin
                    // result already committed; flush has nothing to undo
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // stall is combinational so the MUL is held from its very first cycle;
    // it drops in DONE so the pipeline advances while the product is muxed in.
    assign bus.stall  = !rst && (((state == IDLE) && bus.start && !bus.flush) || (state == RUN));
    assign bus.busy   = (state != IDLE);
    assign bus.err    = !rst && bus.start && (state != IDLE);
    assign bus.done   = done_r;
    assign bus.prodLo = prod_lo;
    assign bus.prodHi = prod_hi;
    assign bus.ofl    = ofl_r;
endmodule
